// File: rtl/edit_mode_controller.sv
// Front-panel edit sequencer: button sync/debounce, RUN/F0/F1/F2 edit FSM, adjust pulses.
// Optional auto-repeat of held inc/dec buttons when EDIT_AUTOREPEAT_EN is defined.
//
// state | meaning
// RUN   | counters advance, no field selected
// F0    | editing sec (time) / day (date)
// F1    | editing min (time) / month (date)
// F2    | editing hour (time) / year (date)
module edit_mode_controller #(
  parameter int DEBOUNCE_CYC     = 1_000_000,
  parameter int REPEAT_DELAY_CYC = 25_000_000,
  parameter int REPEAT_RATE_CYC  = 6_250_000,
  parameter int TIMEOUT_S        = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1s,
  input  logic       sw_mode,
  input  logic       btn_change_n,
  input  logic       btn_inc_n,
  input  logic       btn_dec_n,
  output logic [2:0] field_sel,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       run_en,
  output logic [2:0] edit_led
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DB_W-1:0] DB_LIM = DB_W'(DEBOUNCE_CYC);
  localparam int TO_W = $clog2(TIMEOUT_S + 1);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_S);

  typedef enum logic [1:0] {RUN, F0, F1, F2} state_t;

  state_t state, state_nxt;

  // bit 0 = change, bit 1 = inc, bit 2 = dec
  logic [2:0]      btn_raw, sync1, sync2, deb, db_flip, press_ev;
  logic [DB_W-1:0] db_cnt [3];
  logic [DB_W-1:0] db_cnt_nxt [3];

  logic            chg_ev, inc_ev, dec_ev, any_ev;
  logic            mode_q, mode_edge;
  logic            in_edit, adj_ok, to_hit;
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic            rpt_fire, rpt_dec;
  logic            inc_d, dec_d;
  logic [2:0]      sel_nxt;

  assign btn_raw = {btn_dec_n, btn_inc_n, btn_change_n};

  // The level flips on the cycle the mismatch count would reach the limit,
  // so the press event lands one cycle later and the FSM reacts one after that.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      db_cnt_nxt[i] = (db_cnt[i] == DB_LIM) ? db_cnt[i] : db_cnt[i] + 1'b1;
      db_flip[i]    = (sync2[i] != deb[i]) && (db_cnt_nxt[i] == DB_LIM);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '1;
      sync2    <= '1;
      deb      <= '1;
      press_ev <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i] || db_flip[i]) db_cnt[i] <= '0;
        else                                  db_cnt[i] <= db_cnt_nxt[i];
        if (db_flip[i]) deb[i] <= sync2[i];
        press_ev[i] <= db_flip[i] & ~sync2[i];
      end
    end
  end

  assign chg_ev    = press_ev[0];
  assign inc_ev    = press_ev[1];
  assign dec_ev    = press_ev[2];
  assign any_ev    = |press_ev;
  assign mode_edge = sw_mode ^ mode_q;
  assign in_edit   = (state != RUN);
  assign adj_ok    = in_edit & ~mode_edge & ~chg_ev;

  assign to_cnt_nxt = (to_cnt == TO_LIM) ? to_cnt : to_cnt + 1'b1;
  assign to_hit     = in_edit & tick_1s & (to_cnt_nxt == TO_LIM) & ~any_ev & ~rpt_fire;

`ifdef EDIT_AUTOREPEAT_EN
  localparam int RP_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int RP_W   = $clog2(RP_MAX + 1);
  localparam logic [RP_W-1:0] RP_SAT   = RP_W'(RP_MAX);
  localparam logic [RP_W-1:0] DLY_LIM  = RP_W'(REPEAT_DELAY_CYC);
  localparam logic [RP_W-1:0] RATE_LIM = RP_W'(REPEAT_RATE_CYC);

  logic            rpt_active, rpt_rate, rpt_hold, rpt_start;
  logic [RP_W-1:0] rpt_cnt, rpt_cnt_nxt;

  assign rpt_cnt_nxt = (rpt_cnt == RP_SAT) ? rpt_cnt : rpt_cnt + 1'b1;
  // Repeat only while the owning button alone stays debounced-low.
  assign rpt_hold  = adj_ok & (rpt_dec ? (~deb[2] & deb[1]) : (~deb[1] & deb[2]));
  assign rpt_start = adj_ok & (inc_ev ^ dec_ev);
  assign rpt_fire  = rpt_active & rpt_hold &
                     (rpt_cnt_nxt == (rpt_rate ? RATE_LIM : DLY_LIM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_active <= 1'b0;
      rpt_dec    <= 1'b0;
      rpt_rate   <= 1'b0;
      rpt_cnt    <= '0;
    end else if (rpt_start) begin
      rpt_active <= 1'b1;
      rpt_dec    <= dec_ev;
      rpt_rate   <= 1'b0;
      rpt_cnt    <= '0;
    end else if (!rpt_active || !rpt_hold || state_nxt != state) begin
      rpt_active <= 1'b0;
      rpt_cnt    <= '0;
    end else if (rpt_fire) begin
      rpt_rate <= 1'b1;
      rpt_cnt  <= '0;
    end else begin
      rpt_cnt <= rpt_cnt_nxt;
    end
  end
`else
  assign rpt_fire = 1'b0;
  assign rpt_dec  = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    if (mode_edge) begin
      state_nxt = RUN;
    end else if (chg_ev) begin
      case (state)
        RUN:     state_nxt = F0;
        F0:      state_nxt = F1;
        F1:      state_nxt = F2;
        default: state_nxt = RUN;
      endcase
    end else if (to_hit) begin
      state_nxt = RUN;
    end
  end

  always_comb begin
    inc_d = adj_ok & ((inc_ev & ~dec_ev) | (rpt_fire & ~rpt_dec));
    dec_d = adj_ok & ((dec_ev & ~inc_ev) | (rpt_fire &  rpt_dec));
  end

  always_comb begin
    sel_nxt = 3'b000;
    case (state_nxt)
      F0:      sel_nxt = 3'b001;
      F1:      sel_nxt = 3'b010;
      F2:      sel_nxt = 3'b100;
      default: sel_nxt = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      mode_q    <= 1'b0;
      to_cnt    <= '0;
      field_sel <= 3'b000;
      edit_led  <= 3'b000;
      run_en    <= 1'b1;
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
    end else begin
      state  <= state_nxt;
      mode_q <= sw_mode;
      if (!in_edit || any_ev || rpt_fire) to_cnt <= '0;
      else if (tick_1s)                   to_cnt <= to_cnt_nxt;
      field_sel <= sel_nxt;
      edit_led  <= sel_nxt;
      run_en    <= (state_nxt == RUN);
      inc_pulse <= inc_d;
      dec_pulse <= dec_d;
    end
  end

endmodule

// File: tb/tb_edit_mode_controller.sv
// Directed bench for edit_mode_controller with short debounce/repeat/timeout parameters.
module tb_edit_mode_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1s = 1'b0;
  logic       sw_mode = 1'b0;
  logic       btn_change_n = 1'b1;
  logic       btn_inc_n = 1'b1;
  logic       btn_dec_n = 1'b1;
  logic [2:0] field_sel, edit_led;
  logic       inc_pulse, dec_pulse, run_en;

  int n_checks = 0;
  int n_errors = 0;

  edit_mode_controller #(
    .DEBOUNCE_CYC(4), .REPEAT_DELAY_CYC(20), .REPEAT_RATE_CYC(8), .TIMEOUT_S(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_1s(tick_1s), .sw_mode(sw_mode),
    .btn_change_n(btn_change_n), .btn_inc_n(btn_inc_n), .btn_dec_n(btn_dec_n),
    .field_sel(field_sel), .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
    .run_en(run_en), .edit_led(edit_led)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mask bit 0 = change, 1 = inc, 2 = dec; counts pulses seen during hold and release
  task automatic press(input logic [2:0] mask, input int hold,
                       output int n_inc, output int n_dec, output int n_both);
    n_inc = 0; n_dec = 0; n_both = 0;
    @(posedge clk); #2;
    btn_change_n = ~mask[0];
    btn_inc_n    = ~mask[1];
    btn_dec_n    = ~mask[2];
    for (int i = 0; i < hold + 12; i++) begin
      @(posedge clk); #1;
      if (inc_pulse) n_inc++;
      if (dec_pulse) n_dec++;
      if (inc_pulse && dec_pulse) n_both++;
      if (i == hold - 1) begin
        #1;
        btn_change_n = 1'b1;
        btn_inc_n    = 1'b1;
        btn_dec_n    = 1'b1;
      end
    end
  endtask

  task automatic tick_once(output logic [2:0] fs_after);
    @(posedge clk); #2 tick_1s = 1'b1;
    @(posedge clk); #1 fs_after = field_sel;
    #1 tick_1s = 1'b0;
  endtask

  int         ni, nd, nb, cnt;
  logic [2:0] fs;
  logic [2:0] exp_sel [4];
  logic       exp_run [4];

  initial begin
    exp_sel[0] = 3'b001; exp_sel[1] = 3'b010; exp_sel[2] = 3'b100; exp_sel[3] = 3'b000;
    exp_run[0] = 1'b0;   exp_run[1] = 1'b0;   exp_run[2] = 1'b0;   exp_run[3] = 1'b1;

    #23;
    check("rst_field_sel", field_sel, 3'b000);
    check("rst_edit_led", edit_led, 3'b000);
    check("rst_run_en", run_en, 1'b1);
    check("rst_inc", inc_pulse, 1'b0);
    check("rst_dec", dec_pulse, 1'b0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    for (int k = 0; k < 4; k++) begin
      press(3'b001, 12, ni, nd, nb);
      check($sformatf("chg%0d_field_sel", k), field_sel, exp_sel[k]);
      check($sformatf("chg%0d_edit_led", k), edit_led, exp_sel[k]);
      check($sformatf("chg%0d_run_en", k), run_en, exp_run[k]);
      check($sformatf("chg%0d_no_adj", k), ni + nd, 0);
    end

    press(3'b010, 12, ni, nd, nb);
    check("run_inc_ignored", ni, 0);
    check("run_field_sel", field_sel, 3'b000);

    // F0: timed inc hold
    press(3'b001, 12, ni, nd, nb);
    check("f0_field_sel", field_sel, 3'b001);
    @(posedge clk); #2 btn_inc_n = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("inc_not_early", inc_pulse, 1'b0);
    @(posedge clk); #1 check("inc_latency", inc_pulse, 1'b1);
    check("inc_latency_no_dec", dec_pulse, 1'b0);
    cnt = 0;
    for (int i = 7; i <= 45; i++) begin
      @(posedge clk); #1;
      if (inc_pulse) begin
        cnt++;
`ifdef EDIT_AUTOREPEAT_EN
        check($sformatf("rpt_at_%0d", i), (i == 26 || i == 34 || i == 42), 1'b1);
`endif
      end
    end
`ifdef EDIT_AUTOREPEAT_EN
    check("rpt_count", cnt, 3);
`else
    check("no_repeat", cnt, 0);
`endif
    #1 btn_inc_n = 1'b1;
    repeat (14) @(posedge clk);
    #1 check("f0_hold_field_sel", field_sel, 3'b001);

    // bounce shorter than debounce
    @(posedge clk); #2 btn_inc_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 btn_inc_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (inc_pulse || dec_pulse) cnt++;
    end
    check("bounce_no_pulse", cnt, 0);

    press(3'b100, 12, ni, nd, nb);
    check("f0_dec_count", nd, 1);
    check("f0_dec_no_inc", ni, 0);

    // change + inc together: advance, no pulse
    press(3'b011, 12, ni, nd, nb);
    check("chg_inc_field_sel", field_sel, 3'b010);
    check("chg_inc_no_pulse", ni + nd, 0);

    press(3'b110, 12, ni, nd, nb);
    check("incdec_no_pulse", ni + nd, 0);
    check("incdec_field_sel", field_sel, 3'b010);

    // sw_mode toggle in F1
    @(posedge clk); #2 sw_mode = 1'b1;
    #1 check("mode_before_edge", field_sel, 3'b010);
    @(posedge clk); #1;
    check("mode_abort_field_sel", field_sel, 3'b000);
    check("mode_abort_run_en", run_en, 1'b1);

    // timeout from F2
    for (int k = 0; k < 3; k++) press(3'b001, 12, ni, nd, nb);
    check("f2_field_sel", field_sel, 3'b100);
    tick_once(fs); check("to_tick1", fs, 3'b100);
    tick_once(fs); check("to_tick2", fs, 3'b100);
    tick_once(fs); check("to_tick3_run", fs, 3'b000);
    check("to_run_en", run_en, 1'b1);

    // press after two ticks restarts the count
    press(3'b001, 12, ni, nd, nb);
    tick_once(fs);
    tick_once(fs); check("rs_tick2", fs, 3'b001);
    press(3'b100, 12, ni, nd, nb);
    check("rs_dec_count", nd, 1);
    tick_once(fs);
    tick_once(fs); check("rs_after2", fs, 3'b001);
    tick_once(fs); check("rs_after3_run", fs, 3'b000);
    check("no_overlap", nb, 0);

    // async reset while an inc pulse is high
    press(3'b001, 12, ni, nd, nb);
    @(posedge clk); #2 btn_inc_n = 1'b0;
    repeat (7) @(posedge clk);
    #1 check("pre_rst_inc", inc_pulse, 1'b1);
    check("pre_rst_run_en", run_en, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_field_sel", field_sel, 3'b000);
    check("arst_edit_led", edit_led, 3'b000);
    check("arst_run_en", run_en, 1'b1);
    check("arst_inc", inc_pulse, 1'b0);
    btn_inc_n = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("post_rst_field_sel", field_sel, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
